// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned ARB_N   = 4;
    localparam int unsigned ARB_IDW = 2;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/arb_rr4_if.sv
// Request/grant bundle between the masters and the arbiter.
interface arb_rr4_if;
    import arb_pkg::*;

    logic [ARB_N-1:0]   req;
    logic [ARB_N-1:0]   gnt;
    logic [ARB_IDW-1:0] gnt_id;
    logic               gnt_valid;

    // Requester side
    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    // Arbiter side
    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );

endinterface

// File: rtl/arb_rr4_decoder_2to4.sv
// Plain 2-to-4 one-hot decoder; a is the MSB of the index.
module decoder_2to4 (
    input  logic a,
    input  logic b,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3
);

    // One-hot decode of {a, b}
    always_comb begin
        y0 = ~a & ~b;
        y1 = ~a &  b;
        y2 =  a & ~b;
        y3 =  a &  b;
    end

endmodule

// File: rtl/arb_rr4.sv
// Round-robin arbiter for four masters with a bounded hold time per owner.
module arb_rr4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic       clk,
    input logic       rst_n,
    arb_rr4_if.slave  bus
);

    localparam int unsigned          CntW     = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0]      HoldLast = CntW'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [ARB_IDW-1:0] gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ARB_IDW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]    hold_cnt_q, hold_cnt_d;

    logic [ARB_IDW:0]   win;      // {found, index}
    logic [ARB_IDW:0]   exc_win;  // same search with the owner masked off
    logic [ARB_N-1:0]   others;
    logic               y0, y1, y2, y3;

    // First set bit scanning p, p+1, p+2, p+3 (mod 4); MSB flags a hit.
    function automatic logic [ARB_IDW:0] rr_search(input logic [ARB_N-1:0]   r,
                                                   input logic [ARB_IDW-1:0] p);
        logic [ARB_IDW:0]   res;
        logic [ARB_IDW-1:0] idx;
        res = '0;
        // Descending so the closest offset to p is written last and wins.
        for (int k = ARB_N - 1; k >= 0; k--) begin
            idx = p + ARB_IDW'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Winner searches and next-state decision
    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;

        others  = bus.req & ~(ARB_N'(1) << gnt_id_q);
        win     = rr_search(bus.req, ptr_q);
        exc_win = rr_search(others, ptr_q);

        unique case (state_q)
            IDLE: begin
                if (win[ARB_IDW]) begin
                    state_d     = GRANT;
                    gnt_id_d    = win[ARB_IDW-1:0];
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    ptr_d       = win[ARB_IDW-1:0] + ARB_IDW'(1);
                end
            end
            GRANT: begin
                if (!bus.req[gnt_id_q] || (hold_cnt_q == HoldLast && exc_win[ARB_IDW])) begin
                    // Release or forced rotation: hand over with no idle bubble if possible.
                    if (exc_win[ARB_IDW]) begin
                        gnt_id_d   = exc_win[ARB_IDW-1:0];
                        ptr_d      = exc_win[ARB_IDW-1:0] + ARB_IDW'(1);
                        hold_cnt_d = '0;
                    end else begin
                        state_d     = IDLE;
                        gnt_id_d    = '0;
                        gnt_valid_d = 1'b0;
                        hold_cnt_d  = '0;
                    end
                end else if (hold_cnt_q == HoldLast) begin
                    // Alone at the limit: keep the grant, restart the count.
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    decoder_2to4 u_dec (
        .a  (gnt_id_q[1]),
        .b  (gnt_id_q[0]),
        .y0 (y0),
        .y1 (y1),
        .y2 (y2),
        .y3 (y3)
    );

    // Grant outputs are pure functions of registers
    always_comb begin
        bus.gnt       = {y3, y2, y1, y0} & {ARB_N{gnt_valid_q}};
        bus.gnt_id    = gnt_id_q;
        bus.gnt_valid = gnt_valid_q;
    end

endmodule

// File: tb/tb_arb_rr4.sv
// Directed self-checking bench for arb_rr4 at MAX_HOLD = 8, 4 and 1.
module tb_arb_rr4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb_rr4_if if8 ();
    arb_rr4_if if4 ();
    arb_rr4_if if1 ();

    arb_rr4 #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    arb_rr4 #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    arb_rr4 #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        if8.req  = 4'b0000;
        if4.req  = 4'b0000;
        if1.req  = 4'b0000;

        // Reset values
        #2;
        chk("rst_gnt",       {4'h0, if8.gnt},        8'h00);
        chk("rst_gnt_id",    {6'h0, if8.gnt_id},     8'h00);
        chk("rst_gnt_valid", {7'h0, if8.gnt_valid},  8'h00);
        chk("rst_gnt_h4",    {4'h0, if4.gnt},        8'h00);
        chk("rst_gnt_h1",    {4'h0, if1.gnt},        8'h00);
        #10;
        rst_n = 1'b1;

        // No requests: stay idle
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_gnt",   {4'h0, if8.gnt},       8'h00);
            chk("idle_valid", {7'h0, if8.gnt_valid}, 8'h00);
        end

        // Single requester 2 holds through the hold limit
        if8.req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("single_gnt",    {4'h0, if8.gnt},    8'h04);
            chk("single_gnt_id", {6'h0, if8.gnt_id}, 8'h02);
        end
        // Owner drops; ptr is 3, so master 3 wins over 0 and 1
        if8.req = 4'b1011;
        step();
        chk("ptr3_handover", {4'h0, if8.gnt}, 8'h08);
        if8.req = 4'b0000;
        step();
        chk("ptr3_idle", {4'h0, if8.gnt}, 8'h00);

        // All requesting at MAX_HOLD=4: four cycles each, wraps 3 -> 0
        if4.req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_gnt = 4'b0001 << ((i / 4) % 4);
            chk("rot4_gnt", {4'h0, if4.gnt}, {4'h0, exp_gnt});
        end
        if4.req = 4'b0000;

        // Early release: 0 then 1 with no gap, then idle
        if8.req = 4'b0011;
        step();
        chk("rel_gnt0_a", {4'h0, if8.gnt}, 8'h01);
        step();
        chk("rel_gnt0_b", {4'h0, if8.gnt}, 8'h01);
        if8.req = 4'b0010;
        step();
        chk("rel_gnt1",       {4'h0, if8.gnt},    8'h02);
        chk("rel_gnt1_valid", {7'h0, if8.gnt_valid}, 8'h01);
        if8.req = 4'b0000;
        step();
        chk("rel_idle_gnt",   {4'h0, if8.gnt},       8'h00);
        chk("rel_idle_valid", {7'h0, if8.gnt_valid}, 8'h00);

        // Reset mid-grant clears immediately and restores priority 0 first
        if8.req = 4'b1000;
        step();
        chk("pre_rst_gnt", {4'h0, if8.gnt}, 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt",   {4'h0, if8.gnt},       8'h00);
        chk("async_rst_valid", {7'h0, if8.gnt_valid}, 8'h00);
        if8.req = 4'b1001;
        rst_n   = 1'b1;
        step();
        chk("post_rst_gnt", {4'h0, if8.gnt}, 8'h01);
        if8.req = 4'b0000;

        // MAX_HOLD=1 alternates every cycle
        if1.req = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_gnt = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            chk("fair1_gnt", {4'h0, if1.gnt}, {4'h0, exp_gnt});
        end
        if1.req = 4'b0000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
